// File: rtl/slave_port_burst.sv
// slave_port_burst
//   Bit-serial bus slave port with multi-beat bursts, bridging the serial master
//   bus to a parallel single-port memory.
//   Serial frame (LSB first): ADDR_WIDTH address bits (smode sampled with bit 0),
//   BURST_W length bits (beats = LEN+1), then for writes DATA_WIDTH bits per beat.
//   Read data returns serially on srdata/svalid, one beat at a time.
//   Optional feature: define SPORT_SPLIT_EN to build the split path. The first
//   read beat of each burst then parks in SPLIT/SWAIT until split_grant. With the
//   macro undefined, ssplit is tied low and split_grant is unused.
//
//   Handshake summary: the master presents swdata only when mvalid=1. mvalid=0 is
//   a stall, so the bit counter holds. The port accepts a new frame only while
//   sready=1 (IDLE). Memory strobes smemwen/smemren are single-cycle pulses. A read
//   response is one rvalid pulse carrying smemrdata. svalid=1 qualifies srdata.
module slave_port_burst #(
  parameter int ADDR_WIDTH    = 12,
  parameter int DATA_WIDTH    = 8,
  parameter int BURST_W       = 4,
  parameter int SPLIT_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] smemrdata,
  input  logic                  rvalid,
  output logic                  smemwen,
  output logic                  smemren,
  output logic [ADDR_WIDTH-1:0] smemaddr,
  output logic [DATA_WIDTH-1:0] smemwdata,
  input  logic                  swdata,
  input  logic                  smode,
  input  logic                  mvalid,
  input  logic                  split_grant,
  output logic                  srdata,
  output logic                  svalid,
  output logic                  sready,
  output logic                  ssplit
);

  localparam int MAX_AD  = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CNT_MAX = (MAX_AD > BURST_W) ? MAX_AD : BURST_W;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_ADDR  = 4'd1,
    S_LEN   = 4'd2,
    S_WDATA = 4'd3,
    S_WMEM  = 4'd4,
    S_RREQ  = 4'd5,
    S_RWAIT = 4'd6,
    S_SPLIT = 4'd7,
    S_SWAIT = 4'd8,
    S_RDATA = 4'd9
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      bit_cnt;   // index of the serial bit being captured / presented next
  logic [ADDR_WIDTH-1:0] base;
  logic [BURST_W-1:0]    len;
  logic [BURST_W-1:0]    beat;
  logic                  mode;      // 1 = write burst
  logic [DATA_WIDTH-1:0] wbuf;
  logic [DATA_WIDTH-1:0] rbuf;
  logic                  rbuf_full;

  logic [ADDR_WIDTH-1:0] base_nxt;
  logic [BURST_W-1:0]    len_nxt;
  logic [DATA_WIDTH-1:0] wword;
  logic                  rbit;
  logic [ADDR_WIDTH-1:0] addr_cur;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [BURST_W-1:0]    beat_nxt;
  logic                  rd_state;

`ifdef SPORT_SPLIT_EN
  localparam int SPLIT_W = $clog2(SPLIT_LATENCY + 1);
  logic [SPLIT_W-1:0] split_cnt;
  logic               ssplit_q;
  assign ssplit = ssplit_q;
`else
  logic unused_split;
  assign unused_split = split_grant;
  assign ssplit = 1'b0;
`endif

  // Beat address arithmetic wraps modulo 2^ADDR_WIDTH (carry dropped)
  assign addr_cur = base + ADDR_WIDTH'(beat);
  assign addr_nxt = addr_cur + ADDR_WIDTH'(1);
  assign beat_nxt = beat + BURST_W'(1);
  assign rd_state = (state == S_RREQ) || (state == S_RWAIT) ||
                    (state == S_SPLIT) || (state == S_SWAIT);

  // Bit-indexed insert/extract helpers driven by the shared bit counter
  always_comb begin
    base_nxt = base;
    len_nxt  = len;
    wword    = wbuf;
    rbit     = 1'b0;
    for (int i = 0; i < ADDR_WIDTH; i++) begin
      if (bit_cnt == CNT_W'(i)) base_nxt[i] = swdata;
    end
    for (int i = 0; i < BURST_W; i++) begin
      if (bit_cnt == CNT_W'(i)) len_nxt[i] = swdata;
    end
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (bit_cnt == CNT_W'(i)) begin
        wword[i] = swdata;
        rbit     = rbuf[i];
      end
    end
  end

  // Port FSM with registered outputs; strobes default low so they pulse for one cycle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      base      <= '0;
      len       <= '0;
      beat      <= '0;
      mode      <= 1'b0;
      wbuf      <= '0;
      rbuf      <= '0;
      rbuf_full <= 1'b0;
      smemwen   <= 1'b0;
      smemren   <= 1'b0;
      smemaddr  <= '0;
      smemwdata <= '0;
      srdata    <= 1'b0;
      svalid    <= 1'b0;
      sready    <= 1'b1;
`ifdef SPORT_SPLIT_EN
      split_cnt <= '0;
      ssplit_q  <= 1'b0;
`endif
    end else begin
      smemwen <= 1'b0;
      smemren <= 1'b0;

      // Memory response is captured whenever a read is outstanding
      if (rvalid && rd_state) begin
        rbuf      <= smemrdata;
        rbuf_full <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (mvalid) begin
            mode    <= smode;
            base    <= {{(ADDR_WIDTH-1){1'b0}}, swdata};
            bit_cnt <= CNT_W'(1);
            sready  <= 1'b0;
            state   <= S_ADDR;
          end
        end

        S_ADDR: begin
          if (mvalid) begin
            base <= base_nxt;
            if (bit_cnt == CNT_W'(ADDR_WIDTH-1)) begin
              bit_cnt <= '0;
              state   <= S_LEN;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end

        S_LEN: begin
          if (mvalid) begin
            len <= len_nxt;
            if (bit_cnt == CNT_W'(BURST_W-1)) begin
              bit_cnt <= '0;
              beat    <= '0;
              if (mode) begin
                state <= S_WDATA;
              end else begin
                smemren  <= 1'b1;
                smemaddr <= base;
                state    <= S_RREQ;
              end
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end

        S_WDATA: begin
          if (mvalid) begin
            wbuf <= wword;
            if (bit_cnt == CNT_W'(DATA_WIDTH-1)) begin
              bit_cnt   <= '0;
              smemwen   <= 1'b1;
              smemaddr  <= addr_cur;
              smemwdata <= wword;
              state     <= S_WMEM;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end

        S_WMEM: begin
          if (beat == len) begin
            sready <= 1'b1;
            state  <= S_IDLE;
          end else begin
            beat  <= beat_nxt;
            state <= S_WDATA;
          end
        end

        S_RREQ: begin
`ifdef SPORT_SPLIT_EN
          if (beat == '0) begin
            ssplit_q  <= 1'b1;
            split_cnt <= SPLIT_W'(1);
            state     <= S_SPLIT;
          end else begin
            state <= S_RWAIT;
          end
`else
          state <= S_RWAIT;
`endif
        end

        S_RWAIT: begin
          if (rbuf_full || rvalid) begin
            svalid    <= 1'b1;
            srdata    <= rvalid ? smemrdata[0] : rbuf[0];
            rbuf_full <= 1'b0;
            bit_cnt   <= CNT_W'(1);
            state     <= S_RDATA;
          end
        end

`ifdef SPORT_SPLIT_EN
        S_SPLIT: begin
          if (split_cnt == SPLIT_W'(SPLIT_LATENCY)) begin
            ssplit_q <= 1'b0;
            state    <= S_SWAIT;
          end else begin
            split_cnt <= split_cnt + SPLIT_W'(1);
          end
        end

        S_SWAIT: begin
          if (split_grant && rbuf_full) begin
            svalid    <= 1'b1;
            srdata    <= rbuf[0];
            rbuf_full <= 1'b0;
            bit_cnt   <= CNT_W'(1);
            state     <= S_RDATA;
          end
        end
`endif

        S_RDATA: begin
          if (bit_cnt == CNT_W'(DATA_WIDTH)) begin
            svalid  <= 1'b0;
            srdata  <= 1'b0;
            bit_cnt <= '0;
            if (beat == len) begin
              sready <= 1'b1;
              state  <= S_IDLE;
            end else begin
              beat     <= beat_nxt;
              smemren  <= 1'b1;
              smemaddr <= addr_nxt;
              state    <= S_RREQ;
            end
          end else begin
            srdata  <= rbit;
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end

        default: begin
          sready <= 1'b1;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule
